// File: rtl/mac_seq_driver.sv
// mac_seq_driver: job sequencer feeding a mac_block and returning its results over valid/ready.
// Build option MAC_SEQ_RESULT_FIFO_EN selects a FIFO_DEPTH-entry result FIFO; otherwise a single result register.
module mac_seq_driver #(
    parameter int MIN_W      = 8,
    parameter int ACC_W      = 32,
    parameter int CONF_W     = 3,
    parameter int LEN_W      = 8,
    parameter int MAC_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_mode,
    input  logic                    cmd_acc,
    input  logic [ACC_W-1:0]        cmd_init,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [MIN_W-1:0]        op_a0,
    input  logic [MIN_W-1:0]        op_a1,
    input  logic [MIN_W-1:0]        op_a2,
    input  logic [MIN_W-1:0]        op_a3,
    input  logic [MIN_W-1:0]        op_b,
    output logic                    mac_en,
    output logic [MIN_W-1:0]        mac_a,
    output logic [MIN_W-1:0]        mac_dual_in,
    output logic [MIN_W-1:0]        mac_quad_in1,
    output logic [MIN_W-1:0]        mac_quad_in2,
    output logic [MIN_W-1:0]        mac_b,
    output logic [ACC_W+CONF_W-1:0] mac_cfg,
    input  logic [ACC_W-1:0]        mac_c,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ACC_W-1:0]        res_data,
    output logic                    res_last,
    output logic                    busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [1:0] MODE_DUAL = 2'd1;
    localparam logic [1:0] MODE_QUAD = 2'd2;

`ifdef MAC_SEQ_RESULT_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif
    localparam int RES_SLOTS = FIFO_EN ? FIFO_DEPTH : 1;
    localparam int CNT_W     = $clog2(RES_SLOTS + 1);
    localparam int INF_W     = $clog2(MAC_LAT + 1) + 1;

    logic [1:0]              state_reg;
    logic [1:0]              state_next;
    logic                    armed_reg;
    logic [ACC_W+CONF_W-1:0] cfg_reg;
    logic [ACC_W+CONF_W-1:0] cfg_load;
    logic [LEN_W-1:0]        beats_reg;
    logic [MAC_LAT-1:0]      tag_push_reg;
    logic [MAC_LAT-1:0]      tag_last_reg;
    logic [INF_W-1:0]        inflight_reg;

    logic             cmd_hs;
    logic             op_hs;
    logic             last_beat;
    logic             issue_push;
    logic             exit_push;
    logic             exit_last;
    logic             len0_push;
    logic             push;
    logic             push_last;
    logic [ACC_W-1:0] push_data;
    logic             pop;
    logic [CNT_W-1:0] res_count;
    logic             credit_ok;
    logic             run;
    logic [1:0]       mode;
    logic             acc_sel;

    assign mode      = cfg_reg[1:0];
    assign acc_sel   = cfg_reg[2];
    assign run       = (state_reg == ST_RUN);
    assign busy      = (state_reg != ST_IDLE);
    assign cmd_ready = armed_reg && (state_reg == ST_IDLE);
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign op_ready  = run && credit_ok;
    assign op_hs     = op_valid && op_ready;
    assign mac_en    = op_hs;
    assign mac_cfg   = cfg_reg;
    assign last_beat = (beats_reg == LEN_W'(1));

    // Only beats that will produce a FIFO entry consume a credit; accumulate beats before the last do not.
    assign issue_push = op_hs && (!acc_sel || last_beat);
    assign exit_push  = tag_push_reg[MAC_LAT-1];
    assign exit_last  = tag_last_reg[MAC_LAT-1];
    assign len0_push  = cmd_hs && cmd_acc && (cmd_len == '0);
    assign push       = exit_push || len0_push;
    assign push_data  = exit_push ? mac_c : cmd_init;
    assign push_last  = exit_push ? exit_last : 1'b1;
    assign pop        = res_valid && res_ready;
    assign credit_ok  = (int'(res_count) + int'(inflight_reg)) < RES_SLOTS;

    always_comb begin
        cfg_load                         = '0;
        cfg_load[1:0]                    = cmd_mode;
        cfg_load[2]                      = cmd_acc;
        cfg_load[ACC_W+CONF_W-1:CONF_W]  = cmd_init;
    end

    // Lane gating: unused lanes are forced to zero so the MAC's lane sum only sees active lanes.
    logic [MIN_W-1:0] lane_in  [4];
    logic [MIN_W-1:0] lane_out [4];
    logic [3:0]       lane_use;

    assign lane_in[0] = op_a0;
    assign lane_in[1] = op_a1;
    assign lane_in[2] = op_a2;
    assign lane_in[3] = op_a3;

    always_comb begin
        lane_use = 4'b0001;
        case (mode)
            MODE_DUAL: lane_use = 4'b0011;
            MODE_QUAD: lane_use = 4'b1111;
            default:   lane_use = 4'b0001;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_out[gi] = (run && lane_use[gi]) ? lane_in[gi] : '0;
        end
    endgenerate

    assign mac_a        = lane_out[0];
    assign mac_dual_in  = lane_out[1];
    assign mac_quad_in1 = lane_out[2];
    assign mac_quad_in2 = lane_out[3];
    assign mac_b        = run ? op_b : '0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (cmd_hs) state_next = (cmd_len == '0) ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (op_hs && last_beat) state_next = ST_DRAIN;
            // Leave as the final entry is popped so the next command is taken the following cycle.
            ST_DRAIN: if ((inflight_reg == '0) &&
                          ((res_count == '0) || ((res_count == CNT_W'(1)) && pop)))
                          state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            armed_reg    <= 1'b0;
            cfg_reg      <= '0;
            beats_reg    <= '0;
            inflight_reg <= '0;
            tag_push_reg <= '0;
            tag_last_reg <= '0;
        end else begin
            state_reg <= state_next;
            armed_reg <= 1'b1;
            if (cmd_hs) begin
                cfg_reg   <= cfg_load;
                beats_reg <= cmd_len;
            end else begin
                if (op_hs)
                    beats_reg <= beats_reg - LEN_W'(1);
                if ((state_reg == ST_DRAIN) && (state_next == ST_IDLE))
                    cfg_reg <= '0;
            end
            inflight_reg <= inflight_reg + INF_W'(issue_push) - INF_W'(exit_push);
            tag_push_reg[0] <= issue_push;
            tag_last_reg[0] <= op_hs && last_beat;
            for (int i = 1; i < MAC_LAT; i++) begin
                tag_push_reg[i] <= tag_push_reg[i-1];
                tag_last_reg[i] <= tag_last_reg[i-1];
            end
        end
    end

`ifdef MAC_SEQ_RESULT_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [ACC_W:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [ACC_W:0]     head;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {push_last, push_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(push);
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
            count_reg  <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head      = fifo_mem[rd_ptr_reg];
    assign res_count = count_reg;
    assign res_valid = (count_reg != '0);
    assign res_data  = res_valid ? head[ACC_W-1:0] : '0;
    assign res_last  = res_valid && head[ACC_W];
`else
    logic             full_reg;
    logic [ACC_W-1:0] data_reg;
    logic             last_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_reg <= 1'b0;
            data_reg <= '0;
            last_reg <= 1'b0;
        end else if (push) begin
            full_reg <= 1'b1;
            data_reg <= push_data;
            last_reg <= push_last;
        end else if (pop) begin
            full_reg <= 1'b0;
            data_reg <= '0;
            last_reg <= 1'b0;
        end
    end

    assign res_count = full_reg;
    assign res_valid = full_reg;
    assign res_data  = data_reg;
    assign res_last  = last_reg;
`endif

endmodule

// File: tb/tb_mac_seq_driver.sv
// Directed bench for mac_seq_driver with a small behavioural MAC (all lanes times B, optional accumulate).
module tb_mac_seq_driver;
    localparam int MIN_W      = 8;
    localparam int ACC_W      = 32;
    localparam int CONF_W     = 3;
    localparam int LEN_W      = 8;
    localparam int MAC_LAT    = 1;
    localparam int FIFO_DEPTH = 4;
`ifdef MAC_SEQ_RESULT_FIFO_EN
    localparam int STALL_BEATS = FIFO_DEPTH;
`else
    localparam int STALL_BEATS = 1;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    cmd_valid, cmd_ready, cmd_acc;
    logic [1:0]              cmd_mode;
    logic [ACC_W-1:0]        cmd_init;
    logic [LEN_W-1:0]        cmd_len;
    logic                    op_valid, op_ready;
    logic [MIN_W-1:0]        op_a0, op_a1, op_a2, op_a3, op_b;
    logic                    mac_en;
    logic [MIN_W-1:0]        mac_a, mac_dual_in, mac_quad_in1, mac_quad_in2, mac_b;
    logic [ACC_W+CONF_W-1:0] mac_cfg;
    logic [ACC_W-1:0]        mac_c;
    logic                    res_valid, res_ready, res_last, busy;
    logic [ACC_W-1:0]        res_data;

    always #5 clk = ~clk;

    mac_seq_driver #(
        .MIN_W(MIN_W), .ACC_W(ACC_W), .CONF_W(CONF_W), .LEN_W(LEN_W),
        .MAC_LAT(MAC_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_acc(cmd_acc), .cmd_init(cmd_init), .cmd_len(cmd_len),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a0(op_a0), .op_a1(op_a1), .op_a2(op_a2), .op_a3(op_a3), .op_b(op_b),
        .mac_en(mac_en), .mac_a(mac_a), .mac_dual_in(mac_dual_in),
        .mac_quad_in1(mac_quad_in1), .mac_quad_in2(mac_quad_in2), .mac_b(mac_b),
        .mac_cfg(mac_cfg), .mac_c(mac_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last), .busy(busy)
    );

    // MAC model: sum of all lanes times B, one-cycle latency, accumulator seeded from init on a job's first beat.
    logic [ACC_W-1:0] acc_m, prod_m, sum_m;
    logic             fresh_m;

    always_comb begin
        prod_m = ACC_W'(mac_a) * ACC_W'(mac_b) + ACC_W'(mac_dual_in) * ACC_W'(mac_b)
               + ACC_W'(mac_quad_in1) * ACC_W'(mac_b) + ACC_W'(mac_quad_in2) * ACC_W'(mac_b);
        sum_m  = prod_m;
        if (mac_cfg[2])
            sum_m = (fresh_m ? mac_cfg[ACC_W+CONF_W-1:CONF_W] : acc_m) + prod_m;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_c   <= '0;
            acc_m   <= '0;
            fresh_m <= 1'b0;
        end else begin
            if (cmd_valid && cmd_ready)
                fresh_m <= 1'b1;
            else if (mac_en)
                fresh_m <= 1'b0;
            if (mac_en) begin
                mac_c <= sum_m;
                acc_m <= sum_m;
            end
        end
    end

    int               n_cmp = 0;
    int               n_bad = 0;
    int               n_en  = 0;
    logic             hs_op, hs_cmd;
    logic [ACC_W-1:0] rq_data [$];
    logic             rq_last [$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Samples the cycle's handshakes just before the rising edge, then advances to the next falling edge.
    task automatic step();
        #1;
        if (res_valid && res_ready) begin
            rq_data.push_back(res_data);
            rq_last.push_back(res_last);
        end
        if (mac_en) n_en++;
        hs_op  = op_valid && op_ready;
        hs_cmd = cmd_valid && cmd_ready;
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [1:0] mode, input logic acc,
                            input logic [ACC_W-1:0] init, input logic [LEN_W-1:0] len);
        int k;
        cmd_mode = mode; cmd_acc = acc; cmd_init = init; cmd_len = len; cmd_valid = 1'b1;
        k = 0;
        do begin step(); k++; end while (!hs_cmd && k < 100);
        cmd_valid = 1'b0;
        check_eq("cmd_accept", hs_cmd, 1);
    endtask

    task automatic send_beat(input logic [MIN_W-1:0] a0, input logic [MIN_W-1:0] a1,
                             input logic [MIN_W-1:0] a2, input logic [MIN_W-1:0] a3,
                             input logic [MIN_W-1:0] b);
        int k;
        op_a0 = a0; op_a1 = a1; op_a2 = a2; op_a3 = a3; op_b = b; op_valid = 1'b1;
        k = 0;
        do begin step(); k++; end while (!hs_op && k < 100);
        op_valid = 1'b0;
        check_eq("beat_accept", hs_op, 1);
    endtask

    task automatic wait_results(input int n);
        int k;
        k = 0;
        while (rq_data.size() < n && k < 300) begin step(); k++; end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 100) begin step(); k++; end
        check_eq("idle", busy, 0);
    endtask

    task automatic expect_res(input string tag, input logic [ACC_W-1:0] d, input logic l);
        logic [ACC_W-1:0] gd;
        logic             gl;
        gd = 'x;
        gl = 1'bx;
        if (rq_data.size() > 0) begin
            gd = rq_data.pop_front();
            gl = rq_last.pop_front();
        end
        check_eq({tag, "_data"}, gd, d);
        check_eq({tag, "_last"}, gl, l);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        cmd_valid = 1'b0; cmd_mode = '0; cmd_acc = 1'b0; cmd_init = '0; cmd_len = '0;
        op_valid = 1'b0; op_a0 = '0; op_a1 = '0; op_a2 = '0; op_a3 = '0; op_b = '0;
        res_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_op_ready", op_ready, 0);
        check_eq("rst_mac_cfg", mac_cfg, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        #1;
        check_eq("cmd_ready_after_rst", cmd_ready, 1);

        // SINGLE multiply-only, len 3; unused lanes carry 9 to expose missing gating
        res_ready = 1'b1;
        n_en = 0;
        send_cmd(2'd0, 1'b0, 32'd0, 8'd3);
        send_beat(8'd2, 8'd9, 8'd9, 8'd9, 8'd5);
        send_beat(8'd3, 8'd9, 8'd9, 8'd9, 8'd5);
        send_beat(8'd4, 8'd9, 8'd9, 8'd9, 8'd5);
        wait_results(3);
        wait_idle();
        check_eq("t1_en_count", n_en, 3);
        expect_res("t1_r0", 32'd10, 1'b0);
        expect_res("t1_r1", 32'd15, 1'b0);
        expect_res("t1_r2", 32'd20, 1'b1);
        check_eq("t1_cfg_cleared", mac_cfg, 0);

        // Accumulate SINGLE, init 100: 100 + 3*4 + 5*6 = 142
        n_en = 0;
        send_cmd(2'd0, 1'b1, 32'd100, 8'd2);
        send_beat(8'd3, 8'd9, 8'd9, 8'd9, 8'd4);
        send_beat(8'd5, 8'd9, 8'd9, 8'd9, 8'd6);
        wait_results(1);
        wait_idle();
        repeat (3) step();
        check_eq("t2_en_count", n_en, 2);
        check_eq("t2_n_results", rq_data.size(), 1);
        expect_res("t2_r0", 32'd142, 1'b1);

        // QUAD lanes: (1+2+3+4)*2 = 20
        send_cmd(2'd2, 1'b0, 32'd0, 8'd1);
        op_a0 = 8'd1; op_a1 = 8'd2; op_a2 = 8'd3; op_a3 = 8'd4; op_b = 8'd2;
        #1;
        check_eq("quad_mac_a", mac_a, 1);
        check_eq("quad_dual", mac_dual_in, 2);
        check_eq("quad_q1", mac_quad_in1, 3);
        check_eq("quad_q2", mac_quad_in2, 4);
        check_eq("quad_mac_b", mac_b, 2);
        send_beat(8'd1, 8'd2, 8'd3, 8'd4, 8'd2);
        wait_results(1);
        wait_idle();
        expect_res("quad_r0", 32'd20, 1'b1);

        // DUAL lanes: (1+2)*2 = 6, quad lanes forced to 0
        send_cmd(2'd1, 1'b0, 32'd0, 8'd1);
        op_a0 = 8'd1; op_a1 = 8'd2; op_a2 = 8'd3; op_a3 = 8'd4; op_b = 8'd2;
        #1;
        check_eq("dual_dual", mac_dual_in, 2);
        check_eq("dual_q1", mac_quad_in1, 0);
        check_eq("dual_q2", mac_quad_in2, 0);
        send_beat(8'd1, 8'd2, 8'd3, 8'd4, 8'd2);
        wait_results(1);
        wait_idle();
        expect_res("dual_r0", 32'd6, 1'b1);

        // Back-pressure: len 8 with res_ready low stalls after the credit runs out
        res_ready = 1'b0;
        send_cmd(2'd0, 1'b0, 32'd0, 8'd8);
        k = 0;
        op_a0 = 8'd1; op_a1 = '0; op_a2 = '0; op_a3 = '0; op_b = 8'd3; op_valid = 1'b1;
        repeat (12) begin
            step();
            if (hs_op) begin k++; op_a0 = MIN_W'(k + 1); end
            if (k == 8) op_valid = 1'b0;
        end
        check_eq("bp_accepted_stalled", k, STALL_BEATS);
        #1;
        check_eq("bp_op_ready_low", op_ready, 0);
        res_ready = 1'b1;
        for (int c = 0; c < 200 && k < 8; c++) begin
            step();
            if (hs_op) begin k++; op_a0 = MIN_W'(k + 1); end
        end
        op_valid = 1'b0;
        check_eq("bp_accepted_all", k, 8);
        wait_results(8);
        wait_idle();
        for (int i = 0; i < 8; i++)
            expect_res($sformatf("bp_r%0d", i), ACC_W'((i + 1) * 3), (i == 7));

        // Zero-length jobs
        send_cmd(2'd0, 1'b1, 32'd7, 8'd0);
        wait_results(1);
        wait_idle();
        expect_res("len0_acc", 32'd7, 1'b1);
        send_cmd(2'd0, 1'b0, 32'd0, 8'd0);
        step();
        #1;
        check_eq("len0_mul_busy", busy, 0);
        repeat (3) step();
        check_eq("len0_mul_n_results", rq_data.size(), 0);

        // Reset at beat 2 of 5, then a fresh len-1 job
        send_cmd(2'd0, 1'b0, 32'd0, 8'd5);
        send_beat(8'd1, 8'd0, 8'd0, 8'd0, 8'd1);
        send_beat(8'd2, 8'd0, 8'd0, 8'd0, 8'd1);
        op_a0 = 8'd3; op_b = 8'd1; op_valid = 1'b1;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_op_ready", op_ready, 0);
        check_eq("mid_rst_mac_en", mac_en, 0);
        check_eq("mid_rst_mac_a", mac_a, 0);
        check_eq("mid_rst_res_valid", res_valid, 0);
        check_eq("mid_rst_cfg", mac_cfg, 0);
        op_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rq_data.delete();
        rq_last.delete();
        res_ready = 1'b0;
        send_cmd(2'd0, 1'b0, 32'd0, 8'd1);
        send_beat(8'd6, 8'd9, 8'd9, 8'd9, 8'd7);
        #1;
        check_eq("lat_res_valid_early", res_valid, 0);
        step();
        #1;
        check_eq("lat_res_valid", res_valid, 1);
        check_eq("lat_res_data", res_data, 42);
        check_eq("lat_res_last", res_last, 1);
        res_ready = 1'b1;
        wait_results(1);
        wait_idle();
        repeat (3) step();
        check_eq("post_rst_n_results", rq_data.size(), 1);
        expect_res("post_rst_r0", 32'd42, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
